// File: rtl/nn_pkg.sv
// nn_pkg: shared constants and types for the sliding-window feeder.
//   DATA_WIDTH / ROW_NUM  pixel width and pixels per image column word
//   MODE_*                window-mode encodings
//   K_*                   window width in columns for each mode
//   sld_state_e           feeder FSM states
//   win_k()               window width for a given mode
package nn_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ROW_NUM    = 6;

  localparam logic [1:0] MODE_3X3 = 2'b00;
  localparam logic [1:0] MODE_6X6 = 2'b01;

  localparam logic [2:0] K_3X3 = 3'd3;
  localparam logic [2:0] K_6X6 = 3'd6;

  // StDrain is the quiet cycle that carries the last shift of a fill/slide burst.
  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StSlide,
    StDrain,
    StWait,
    StDone
  } sld_state_e;

  // Any mode other than MODE_3X3 selects the 6-column window.
  function automatic logic [2:0] win_k(input logic [1:0] mode);
    return (mode == MODE_3X3) ? K_3X3 : K_6X6;
  endfunction

endpackage

// File: rtl/nn_sld_addr_gen.sv
// nn_sld_addr_gen: image column address generator.
//   i_clk, i_rst   clock, asynchronous active-low reset
//   i_load         capture i_base and restart the column count at 0
//   i_base         SRAM address of image column 0
//   i_inc          advance the column count by one
//   o_addr         base + column count, wrapping modulo 2^ADDR_W
//   o_col_cnt      number of columns advanced since the last load
module nn_sld_addr_gen #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned COL_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_addr,
  output logic [COL_W-1:0]  o_col_cnt
);

  logic [ADDR_W-1:0] r_base;
  logic [COL_W-1:0]  r_col_cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_base    <= '0;
      r_col_cnt <= '0;
    end else if (i_load) begin
      r_base    <= i_base;
      r_col_cnt <= '0;
    end else if (i_inc) begin
      r_col_cnt <= r_col_cnt + COL_W'(1);
    end
  end

  assign o_addr    = r_base + ADDR_W'(r_col_cnt);
  assign o_col_cnt = r_col_cnt;

endmodule

// File: rtl/nn_sld_feeder.sv
// nn_sld_feeder: column sequencer feeding the sliding-window register file.
// Reads one image column per cycle from SRAM, fills a K-column window, then slides it by
// the stride each time the PE array consumes a window.
//   i_clk, i_rst            clock, asynchronous active-low reset
//   i_start                 job start pulse (accepted only when idle)
//   i_mode, i_3x3           window mode and 3x3 half select, latched at start
//   i_base_addr, i_img_w    image base address and width in columns
//   i_stride                columns per slide (0 behaves as 1)
//   o_mem_addr, o_mem_rd    SRAM read port; data returns the following cycle
//   i_mem_data, o_data      SRAM column, passed straight through to the RF
//   o_shift                 RF shift strobe (read enable delayed one cycle)
//   o_mode, o_3x3           latched mode/select to the RF
//   o_win_valid             complete window present, held until i_win_ready
//   o_busy, o_done          job in progress / single-cycle end-of-job pulse
module nn_sld_feeder
  import nn_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned COL_W  = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [1:0]                    i_mode,
  input  logic                          i_3x3,
  input  logic [ADDR_W-1:0]             i_base_addr,
  input  logic [COL_W-1:0]              i_img_w,
  input  logic [1:0]                    i_stride,
  output logic [ADDR_W-1:0]             o_mem_addr,
  output logic                          o_mem_rd,
  input  logic [DATA_WIDTH*ROW_NUM-1:0] i_mem_data,
  output logic [DATA_WIDTH*ROW_NUM-1:0] o_data,
  output logic                          o_shift,
  output logic [1:0]                    o_mode,
  output logic                          o_3x3,
  output logic                          o_win_valid,
  input  logic                          i_win_ready,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int unsigned CntW = COL_W + 1;

  sld_state_e       r_state;
  logic             r_mem_rd;
  logic             r_shift;
  logic             r_win_valid;
  logic             r_busy;
  logic             r_done;
  logic [1:0]       r_mode;
  logic             r_3x3;
  logic [COL_W-1:0] r_img_w;
  logic [1:0]       r_stride;
  logic [2:0]       r_rd_left;

  logic [2:0]       w_start_k;
  logic [1:0]       w_start_stride;
  logic             w_short;
  logic             w_load;
  logic [COL_W-1:0] w_col_cnt;
  logic [CntW-1:0]  w_next_cnt;
  logic             w_last;

  assign w_start_k      = win_k(i_mode);
  assign w_start_stride = (i_stride == 2'd0) ? 2'd1 : i_stride;
  assign w_short        = i_img_w < COL_W'(w_start_k);
  assign w_load         = (r_state == StIdle) && i_start && !w_short;

  // One extra bit so the end-of-image test cannot wrap near 2^COL_W-1.
  assign w_next_cnt = CntW'(w_col_cnt) + CntW'(r_stride);
  assign w_last     = w_next_cnt > CntW'(r_img_w);

  // The column count advances on every read, so o_mem_addr already points at the next column.
  nn_sld_addr_gen #(
    .ADDR_W (ADDR_W),
    .COL_W  (COL_W)
  ) u_addr_gen (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_load),
    .i_base    (i_base_addr),
    .i_inc     (r_mem_rd),
    .o_addr    (o_mem_addr),
    .o_col_cnt (w_col_cnt)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= StIdle;
      r_mem_rd    <= 1'b0;
      r_shift     <= 1'b0;
      r_win_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mode      <= 2'b00;
      r_3x3       <= 1'b0;
      r_img_w     <= '0;
      r_stride    <= 2'd0;
      r_rd_left   <= 3'd0;
    end else begin
      r_shift <= r_mem_rd;
      r_done  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_mode   <= i_mode;
            r_3x3    <= i_3x3;
            r_img_w  <= i_img_w;
            r_stride <= w_start_stride;
            if (w_short) begin
              // Not even one window fits: finish without touching memory.
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_state   <= StFill;
              r_mem_rd  <= 1'b1;
              r_busy    <= 1'b1;
              r_rd_left <= w_start_k - 3'd1;
            end
          end
        end
        StFill, StSlide: begin
          // r_rd_left counts reads still owed after the one in flight this cycle.
          if (r_rd_left == 3'd0) begin
            r_mem_rd <= 1'b0;
            r_state  <= StDrain;
          end else begin
            r_rd_left <= r_rd_left - 3'd1;
          end
        end
        StDrain: begin
          r_win_valid <= 1'b1;
          r_state     <= StWait;
        end
        StWait: begin
          if (i_win_ready) begin
            r_win_valid <= 1'b0;
            if (w_last) begin
              r_state <= StDone;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state   <= StSlide;
              r_mem_rd  <= 1'b1;
              r_rd_left <= {1'b0, r_stride} - 3'd1;
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_data      = i_mem_data;
  assign o_mem_rd    = r_mem_rd;
  assign o_shift     = r_shift;
  assign o_win_valid = r_win_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_mode      = r_mode;
  assign o_3x3       = r_3x3;

endmodule
